// File: rtl/muxes_pkg.sv
// Shared constants and types for the registered 4:1 selector bank.
package muxes_pkg;

    localparam int unsigned SEL_W    = 2;
    localparam int unsigned LANES    = 4;
    localparam int unsigned DATA_LSB = 2;

    // Index of one lane in the four-lane selector bank.
    typedef logic [SEL_W-1:0] lane_t;

endpackage : muxes_pkg

// File: rtl/muxes_mux4.sv
// One-bit 4:1 combinational multiplexer with a 2-bit select.
module mux4
    import muxes_pkg::*;
(
    input  logic [LANES-1:0] d,
    input  lane_t            sel,
    output logic             y
);

    // Pure select decode: every select code maps to exactly one lane.
    always_comb begin
        y = d[0];
        case (sel)
            2'd0: y = d[0];
            2'd1: y = d[1];
            2'd2: y = d[2];
            2'd3: y = d[3];
            default: y = d[0];
        endcase
    end

endmodule : mux4

// File: rtl/muxes_top.sv
// Bank of four registered selectors: selected input bit, selected data bit,
// their AND and their XOR, all registered with one cycle of latency.
module muxes_top
    import muxes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0_top,
    input  logic       in1_top,
    input  logic       in2_top,
    input  logic       in3_top,
    input  logic [1:0] sel,
    input  logic [5:2] data,
    output logic       out0,
    output logic       out1,
    output logic       out2,
    output logic       out3
);

    logic [LANES-1:0] in_v;
    logic [LANES-1:0] d_v;
    logic             a;
    logic             b;

    // Pack the lane inputs and rebase the data word so lane k uses data[k+2].
    always_comb begin
        in_v = {in3_top, in2_top, in1_top, in0_top};
        d_v  = {data[DATA_LSB+3], data[DATA_LSB+2], data[DATA_LSB+1], data[DATA_LSB]};
    end

    mux4 u_mux_in (
        .d   (in_v),
        .sel (lane_t'(sel)),
        .y   (a)
    );

    mux4 u_mux_data (
        .d   (d_v),
        .sel (lane_t'(sel)),
        .y   (b)
    );

    // Output flops: reset wins over loading; otherwise load every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0 <= 1'b0;
            out1 <= 1'b0;
            out2 <= 1'b0;
            out3 <= 1'b0;
        end else begin
            out0 <= a;
            out1 <= b;
            out2 <= a & b;
            out3 <= a ^ b;
        end
    end

endmodule : muxes_top

// File: tb/tb_muxes_top.sv
// Scoreboard bench for muxes_top: directed vectors with hand-computed
// expectations {out3,out2,out1,out0}, checked one edge after they are driven.
module tb_muxes_top;

    logic       clk;
    logic       rst_n;
    logic       in0_top, in1_top, in2_top, in3_top;
    logic [1:0] sel;
    logic [5:2] data;
    logic       out0, out1, out2, out3;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    logic [3:0] last_exp;

    muxes_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in0_top (in0_top),
        .in1_top (in1_top),
        .in2_top (in2_top),
        .in3_top (in3_top),
        .sel     (sel),
        .data    (data),
        .out0    (out0),
        .out1    (out1),
        .out2    (out2),
        .out3    (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and queue the response expected
    // after the next rising edge. With hold=1 the outputs are also checked
    // to still show the previous result between edges.
    task automatic step(input logic r, input logic [3:0] inv, input logic [1:0] s,
                        input logic [3:0] dv, input logic [3:0] exp,
                        input string tag, input logic hold);
        @(negedge clk);
        rst_n   = r;
        {in3_top, in2_top, in1_top, in0_top} = inv;
        sel     = s;
        data    = dv;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (hold) begin
            #2;
            checks++;
            if ({out3, out2, out1, out0} !== last_exp) begin
                errors++;
                $display("FAIL %s_hold: out=%b expected %b", tag, {out3, out2, out1, out0}, last_exp);
            end
        end
        last_exp = exp;
    endtask

    // Monitor: after every rising edge, compare outputs to the oldest entry.
    initial begin
        logic [3:0] e;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if ({out3, out2, out1, out0} !== e) begin
                    errors++;
                    $display("FAIL %s: out=%b expected %b", t, {out3, out2, out1, out0}, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {in3_top, in2_top, in1_top, in0_top} = 4'b0000;
        sel = 2'd0;
        data = 4'h0;
        last_exp = 4'b0000;

        // Reset with all inputs high, then release.
        step(1'b0, 4'b1111, 2'd3, 4'hF, 4'b0000, "rst_a", 1'b0);
        step(1'b0, 4'b1111, 2'd3, 4'hF, 4'b0000, "rst_b", 1'b0);
        step(1'b1, 4'b1111, 2'd3, 4'hF, 4'b0111, "rst_release", 1'b0);

        // Input sweep: in0..in3 = 1,0,1,0, data = 0.
        step(1'b1, 4'b0101, 2'd0, 4'h0, 4'b1001, "in_sel0", 1'b0);
        step(1'b1, 4'b0101, 2'd1, 4'h0, 4'b0000, "in_sel1", 1'b0);
        step(1'b1, 4'b0101, 2'd2, 4'h0, 4'b1001, "in_sel2", 1'b0);
        step(1'b1, 4'b0101, 2'd3, 4'h0, 4'b0000, "in_sel3", 1'b0);

        // Data sweep: inputs 0, data[4] and data[3] set.
        step(1'b1, 4'b0000, 2'd0, 4'b0110, 4'b0000, "d_sel0", 1'b0);
        step(1'b1, 4'b0000, 2'd1, 4'b0110, 4'b1010, "d_sel1", 1'b0);
        step(1'b1, 4'b0000, 2'd2, 4'b0110, 4'b1010, "d_sel2", 1'b0);
        step(1'b1, 4'b0000, 2'd3, 4'b0110, 4'b0000, "d_sel3", 1'b0);

        // AND/XOR on lane 2.
        step(1'b1, 4'b0100, 2'd2, 4'b0100, 4'b0111, "andxor_11", 1'b0);
        step(1'b1, 4'b0100, 2'd2, 4'b0000, 4'b1001, "andxor_10", 1'b0);

        // Mid-stream reset during a sel sweep.
        step(1'b1, 4'b0101, 2'd0, 4'b0110, 4'b1001, "mid_sel0", 1'b0);
        step(1'b1, 4'b0101, 2'd1, 4'b0110, 4'b1010, "mid_sel1", 1'b0);
        step(1'b0, 4'b0101, 2'd2, 4'b0110, 4'b0000, "mid_rst", 1'b0);
        step(1'b1, 4'b0101, 2'd2, 4'b0110, 4'b0111, "mid_resume2", 1'b0);
        step(1'b1, 4'b0101, 2'd3, 4'b0110, 4'b0000, "mid_resume3", 1'b0);

        // Latency: toggle in1 with sel = 1; outputs must not move before the edge.
        step(1'b1, 4'b0010, 2'd1, 4'h0, 4'b1001, "lat_1", 1'b1);
        step(1'b1, 4'b0000, 2'd1, 4'h0, 4'b0000, "lat_0", 1'b1);
        step(1'b1, 4'b0010, 2'd1, 4'h0, 4'b1001, "lat_1b", 1'b1);
        step(1'b1, 4'b0000, 2'd1, 4'h0, 4'b0000, "lat_0b", 1'b1);

        // Let the monitor drain; a leftover entry means a response never came.
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_muxes_top
